// File: rtl/lr_pkg.sv
// Shared definitions for the linear-regression sequencing controller.
//   - lr_state_e : controller states, one per pass/strobe phase.
//   - lr_regs_t  : one bit per datapath register (used for clr and ld).
//   - lr_strobe_t: the complete clear/load strobe set.
//   - lr_decode  : maps a state to the strobes that state asserts.
package lr_pkg;

  localparam int unsigned LR_N_SAMPLES = 150;
  localparam int unsigned LR_ADDR_W    = 8;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    SUM,
    MEAN,
    COV,
    B1,
    B0,
    ERR,
    DONE
  } lr_state_e;

  typedef struct packed {
    logic psumx;
    logic psumy;
    logic meanx;
    logic meany;
    logic sumxx;
    logic sumxy;
    logic b0;
    logic b1;
  } lr_regs_t;

  typedef struct packed {
    lr_regs_t clr;
    lr_regs_t ld;
  } lr_strobe_t;

  // States that walk the sample memory.
  function automatic logic lr_is_count_state(input lr_state_e s);
    return (s == SUM) || (s == COV) || (s == ERR);
  endfunction

  // Each state owns at most one strobe group, so clears and loads can
  // never overlap and no two load groups fire together.
  function automatic lr_strobe_t lr_decode(input lr_state_e s);
    lr_strobe_t st;
    st = '0;
    case (s)
      INIT: st.clr = '1;
      SUM: begin
        st.ld.psumx = 1'b1;
        st.ld.psumy = 1'b1;
      end
      MEAN: begin
        st.ld.meanx = 1'b1;
        st.ld.meany = 1'b1;
      end
      COV: begin
        st.ld.sumxx = 1'b1;
        st.ld.sumxy = 1'b1;
      end
      B1:      st.ld.b1 = 1'b1;
      B0:      st.ld.b0 = 1'b1;
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/lr_addr_counter.sv
// Modulo-N sample address counter.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   clr      : force the address to 0 (takes priority over en)
//   en       : advance by one, wrapping N-1 -> 0
//   addr     : current sample index (registered)
//   last     : addr == N-1
module lr_addr_counter
  import lr_pkg::*;
#(
  parameter int unsigned N_SAMPLES = LR_N_SAMPLES,
  parameter int unsigned ADDR_W    = LR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (en) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (addr_q == LAST_ADDR);

endmodule

// File: rtl/lr_seq_ctrl.sv
// Sequencing controller for the linear-regression datapath.
// A fit runs on request in three passes over the sample set (sums,
// covariance, error) with single-cycle mean/B1/B0 load steps between.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   start         : request a fit; only looked at while idle
//   busy          : high in every state except IDLE
//   done          : one-cycle pulse when the error pass has finished
//   addr          : sample index to the sample memories
//   err_valid     : datapath error output valid for current addr
//   clr_* / ld_*  : datapath register clear / load strobes
// All outputs are registered and depend only on controller state.
module lr_seq_ctrl
  import lr_pkg::*;
#(
  parameter int unsigned N_SAMPLES = LR_N_SAMPLES,
  parameter int unsigned ADDR_W    = LR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic              err_valid,
  output logic              clr_psumx,
  output logic              clr_psumy,
  output logic              clr_meanx,
  output logic              clr_meany,
  output logic              clr_sumxx,
  output logic              clr_sumxy,
  output logic              clr_B0,
  output logic              clr_B1,
  output logic              ld_psumx,
  output logic              ld_psumy,
  output logic              ld_meanx,
  output logic              ld_meany,
  output logic              ld_sumxx,
  output logic              ld_sumxy,
  output logic              ld_B0,
  output logic              ld_B1
);

  lr_state_e  state_q, state_d;
  lr_strobe_t strb_q, strb_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_valid_q, err_valid_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_last;

  // The counter runs only in pass states and is held at 0 elsewhere, so
  // every pass enters at 0; the wrap on the exit cycle also lands on 0.
  assign cnt_en  = lr_is_count_state(state_q);
  assign cnt_clr = ~cnt_en;

  lr_addr_counter #(
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W)
  ) u_addr_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .addr (addr),
    .last (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = SUM;
      SUM:     if (cnt_last) state_d = MEAN;
      MEAN:    state_d = COV;
      COV:     if (cnt_last) state_d = B1;
      B1:      state_d = B0;
      B0:      state_d = ERR;
      ERR:     if (cnt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they
    // line up with state_q in the cycle that state is occupied.
    strb_d      = lr_decode(state_d);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    err_valid_d = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      strb_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      strb_q      <= strb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_valid = err_valid_q;

  assign clr_psumx = strb_q.clr.psumx;
  assign clr_psumy = strb_q.clr.psumy;
  assign clr_meanx = strb_q.clr.meanx;
  assign clr_meany = strb_q.clr.meany;
  assign clr_sumxx = strb_q.clr.sumxx;
  assign clr_sumxy = strb_q.clr.sumxy;
  assign clr_B0    = strb_q.clr.b0;
  assign clr_B1    = strb_q.clr.b1;

  assign ld_psumx  = strb_q.ld.psumx;
  assign ld_psumy  = strb_q.ld.psumy;
  assign ld_meanx  = strb_q.ld.meanx;
  assign ld_meany  = strb_q.ld.meany;
  assign ld_sumxx  = strb_q.ld.sumxx;
  assign ld_sumxy  = strb_q.ld.sumxy;
  assign ld_B0     = strb_q.ld.b0;
  assign ld_B1     = strb_q.ld.b1;

endmodule

// File: tb/tb_lr_seq_ctrl.sv
// Directed bench for lr_seq_ctrl with one N=4 and one N=1 instance.
// Observed output vector layout (27 bits):
//   {busy, done, err_valid, clr[7:0], ld[7:0], addr[7:0]}
//   register bit order: psumx psumy meanx meany sumxx sumxy B0 B1
module tb_lr_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st4 = 1'b0;
  logic st1 = 1'b0;

  always #5 clk = ~clk;

  logic       busy4, done4, errv4;
  logic [7:0] addr4, clr4, ld4;
  logic       busy1, done1, errv1;
  logic [7:0] addr1, clr1, ld1;

  int n_vec = 0;
  int n_err = 0;

  lr_seq_ctrl #(.N_SAMPLES(4), .ADDR_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(st4),
    .busy(busy4), .done(done4), .addr(addr4), .err_valid(errv4),
    .clr_psumx(clr4[7]), .clr_psumy(clr4[6]), .clr_meanx(clr4[5]),
    .clr_meany(clr4[4]), .clr_sumxx(clr4[3]), .clr_sumxy(clr4[2]),
    .clr_B0(clr4[1]), .clr_B1(clr4[0]),
    .ld_psumx(ld4[7]), .ld_psumy(ld4[6]), .ld_meanx(ld4[5]),
    .ld_meany(ld4[4]), .ld_sumxx(ld4[3]), .ld_sumxy(ld4[2]),
    .ld_B0(ld4[1]), .ld_B1(ld4[0])
  );

  lr_seq_ctrl #(.N_SAMPLES(1), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(st1),
    .busy(busy1), .done(done1), .addr(addr1), .err_valid(errv1),
    .clr_psumx(clr1[7]), .clr_psumy(clr1[6]), .clr_meanx(clr1[5]),
    .clr_meany(clr1[4]), .clr_sumxx(clr1[3]), .clr_sumxy(clr1[2]),
    .clr_B0(clr1[1]), .clr_B1(clr1[0]),
    .ld_psumx(ld1[7]), .ld_psumy(ld1[6]), .ld_meanx(ld1[5]),
    .ld_meany(ld1[4]), .ld_sumxx(ld1[3]), .ld_sumxy(ld1[2]),
    .ld_B0(ld1[1]), .ld_B1(ld1[0])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] obs(input int sel);
    if (sel == 4) return {busy4, done4, errv4, clr4, ld4, addr4};
    return {busy1, done1, errv1, clr1, ld1, addr1};
  endfunction

  // Expected outputs in cycle c of a run (c = 0 means idle), from the
  // published schedule: INIT 1, SUM 2..n+1, MEAN n+2, COV n+3..2n+2,
  // B1 2n+3, B0 2n+4, ERR 2n+5..3n+4, DONE 3n+5.
  function automatic logic [26:0] exp_vec(input int n, input int c);
    logic       busy, done, errv;
    logic [7:0] clr, ld, addr;
    busy = 1'b0; done = 1'b0; errv = 1'b0;
    clr = 8'h00; ld = 8'h00; addr = 8'h00;
    if (c >= 1 && c <= 3*n + 5) begin
      busy = 1'b1;
      if (c == 1) clr = 8'hFF;
      else if (c <= n + 1) begin
        ld = 8'b1100_0000; addr = 8'(c - 2);
      end else if (c == n + 2) ld = 8'b0011_0000;
      else if (c <= 2*n + 2) begin
        ld = 8'b0000_1100; addr = 8'(c - n - 3);
      end else if (c == 2*n + 3) ld = 8'b0000_0001;
      else if (c == 2*n + 4) ld = 8'b0000_0010;
      else if (c <= 3*n + 4) begin
        errv = 1'b1; addr = 8'(c - 2*n - 5);
      end else done = 1'b1;
    end
    return {busy, done, errv, clr, ld, addr};
  endfunction

  task automatic chk_cyc(input int sel, input int n, input int c, input string tag);
    logic [26:0] o;
    int          groups;
    o = obs(sel);
    chk($sformatf("%s c%0d", tag, c), 32'(o), 32'(exp_vec(n, c)));
    if (sel == 4) begin
      groups = int'(|ld4[7:6]) + int'(|ld4[5:4]) + int'(|ld4[3:2]) +
               int'(ld4[1]) + int'(ld4[0]);
      chk($sformatf("%s excl c%0d", tag, c),
          32'((groups <= 1) && !((|clr4) && (|ld4))), 32'd1);
    end
  endtask

  // Full N=4 run; start re-asserted during cycles ra and rb.
  task automatic run4(input string tag, input int ra, input int rb);
    st4 = 1'b1;
    tick();
    for (int c = 1; c <= 17; c++) begin
      chk_cyc(4, 4, c, tag);
      st4 = (c == ra || c == rb);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      chk_cyc(4, 4, 0, {tag, "_idle"});
      tick();
    end
  endtask

  initial begin
    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cyc(4, 4, 0, "rst4");
      chk_cyc(1, 1, 0, "rst1");
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_cyc(4, 4, 0, "idle4");
      chk_cyc(1, 1, 0, "idle1");
    end

    run4("run", 0, 0);
    run4("restart", 3, 10);

    // Reset mid-run in COV at addr = 2 (cycle 9 for N=4).
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk_cyc(4, 4, c, "pre_rst");
      if (c == 9) rst = 1'b1;
      tick();
    end
    chk_cyc(4, 4, 0, "mid_rst");
    rst = 1'b0;
    tick();
    chk_cyc(4, 4, 0, "post_rst");
    run4("after_rst", 0, 0);

    // N=1 single run.
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk_cyc(1, 1, c, "n1");
      tick();
    end
    chk_cyc(1, 1, 0, "n1_idle");

    // N=1 with start held: second run begins from IDLE in cycle 9.
    st1 = 1'b1;
    tick();
    for (int c = 1; c <= 17; c++) begin
      chk_cyc(1, 1, (c <= 8) ? c : (c == 9) ? 0 : c - 9, "n1_b2b");
      if (c == 17) st1 = 1'b0;
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      chk_cyc(1, 1, 0, "n1_b2b_idle");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
